// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator: one binary shift step per register stage,
// all stages advancing together under a single stall signal.
module shift_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [2:0]               op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     carry,
    output logic                     zero,
    output logic                     err
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        logic [SHW-1:0]   shamt;
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             err;
        logic             zero;
    } stage_t;

    logic   advance;
    stage_t head;
    stage_t tail;

    // Every stage moves only when the output slot is empty or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operation as offered; illegal ops are flagged here and never shifted.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.op    = op;
        head.shamt = shamt;
        head.data  = din;
        head.err   = (op > OP_ROR);
    end

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        localparam int unsigned K  = 1 << i;
        localparam int unsigned HI = WIDTH - K;

        stage_t           src;
        stage_t           nxt;
        stage_t           q;
        logic [WIDTH-1:0] rot;

        if (i == 0) begin : g_first
            assign src = head;
        end else begin : g_next
            assign src = g_stage[i-1].q;
        end

        // Carry always tracks the most recent bit pushed out, so the last
        // active stage leaves exactly the bit the full shift would drop.
        always_comb begin
            nxt = src;
            rot = '0;
            if (src.shamt[i] && !src.err) begin
                case (src.op)
                    OP_SLL: begin
                        nxt.data  = src.data << K;
                        nxt.carry = src.data[HI];
                    end
                    OP_SRL: begin
                        nxt.data  = src.data >> K;
                        nxt.carry = src.data[K-1];
                    end
                    OP_SRA: begin
                        nxt.data  = WIDTH'($signed(src.data) >>> K);
                        nxt.carry = src.data[K-1];
                    end
                    OP_ROL: begin
                        rot       = (src.data << K) | (src.data >> HI);
                        nxt.data  = rot;
                        nxt.carry = rot[0];
                    end
                    OP_ROR: begin
                        rot       = (src.data >> K) | (src.data << HI);
                        nxt.data  = rot;
                        nxt.carry = rot[WIDTH-1];
                    end
                    default: ;
                endcase
            end
            nxt.zero = (nxt.data == '0);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= '0;
            end else if (advance) begin
                q <= nxt;
            end
        end
    end

    assign tail      = g_stage[SHW-1].q;
    assign out_valid = tail.valid;
    assign dout      = tail.data;
    assign carry     = tail.carry;
    assign zero      = tail.zero;
    assign err       = tail.err;

    // Control fields have no consumer once the final stage is reached.
    logic unused_ctl;
    assign unused_ctl = ^{tail.op, tail.shamt};

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width; legal values are powers of two from 4 to 64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), which is both the shift-amount width and the pipeline depth.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 SHALL have port din, input, WIDTH bits: operand.
REQ-008 SHALL have port shamt, input, SHW bits: shift amount, 0..WIDTH-1.
REQ-009 SHALL have port op, input, 3 bits: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 are illegal.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port dout, output, WIDTH bits: result.
REQ-013 SHALL have port carry, output, 1 bit: the last bit shifted out, or the last bit wrapped for rotates.
REQ-014 SHALL have port zero, output, 1 bit: dout == 0.
REQ-015 SHALL have port err, output, 1 bit: the op was illegal.

Function
REQ-016 SHALL accept an operation in any cycle where in_valid && in_ready are both high; din, shamt and op are sampled only in that cycle.
REQ-017 SHALL compute results in SHW register stages; stage i applies a shift of 2^(i-1) when shamt[i-1] is set.
REQ-018 SHALL present an operation accepted in cycle c with out_valid=1 in cycle c+SHW when there is no back-pressure.
REQ-019 SHALL transfer a result in a cycle where out_valid && out_ready are both high.
REQ-020 SHALL use the stall rule: advance = !out_valid || out_ready; all stages move together only when advance=1.
REQ-021 SHALL drive in_ready = advance, combinationally from out_valid and out_ready.
REQ-022 SHALL hold dout, carry, zero, err and out_valid stable while out_valid=1 && out_ready=0.
REQ-023 SHALL sustain throughput of one operation per cycle when out_ready is held at 1.
REQ-024 SHALL let bubbles (stage valid=0) propagate; a bubble never produces out_valid.
REQ-025 SHALL compute SLL as din << shamt, zero-filled.
REQ-026 SHALL compute SRL as din >> shamt, zero-filled.
REQ-027 SHALL compute SRA as din >> shamt, filled with din[WIDTH-1].
REQ-028 SHALL compute ROL as rotate left by shamt, with no fill.
REQ-029 SHALL compute ROR as rotate right by shamt, with no fill.
REQ-030 SHALL drive carry for SLL with shamt=s>0 as din[WIDTH-s].
REQ-031 SHALL drive carry for SRL or SRA with s>0 as din[s-1].
REQ-032 SHALL drive carry for ROL with s>0 as dout[0], and for ROR with s>0 as dout[WIDTH-1].
REQ-033 SHALL drive carry=0 whenever shamt=0, for every op.
REQ-034 SHALL pass an illegal op through with dout=din, carry=0, err=1, zero computed on dout, and the same latency.
REQ-035 SHALL keep every result in accept order, with none dropped or duplicated under any out_ready pattern.
REQ-036 SHALL ignore in_valid while in_ready=0; the offered operation is not captured.

Reset
REQ-037 SHALL, on a rising edge with rst_n=0, clear every stage valid bit, so out_valid=0 in the following cycle.
REQ-038 SHALL reset dout, carry, zero and err to 0; zero resets to 0, not 1.
REQ-039 SHALL discard all in-flight operations on reset mid-operation and produce no result for them after reset release.
REQ-040 SHALL accept no operation in a cycle with rst_n=0, and SHALL drive in_ready=1 in the first cycle after release.

Verification (WIDTH=8, SHW=3)
REQ-041 SHALL cover: SRA din=8'b1001_0110, shamt=3 -> dout=8'b1111_0010, carry=1, zero=0, 3 cycles after accept.
REQ-042 SHALL cover: ROL din=8'hA5, shamt=1 -> dout=8'h4B, carry=1; ROR din=8'h01, shamt=1 -> dout=8'h80, carry=1.
REQ-043 SHALL cover: SLL din=8'h81, shamt=7 -> dout=8'h80, carry=0; SRL din=8'h01, shamt=1 -> dout=8'h00, carry=1, zero=1.
REQ-044 SHALL cover: 10 back-to-back ops with out_ready=0 for cycles 4-8 -> in_ready=0 while the 3 stages are full, all 10 results delivered in order, outputs stable during the stall.
REQ-045 SHALL cover: op=3'b111, din=8'h3C -> dout=8'h3C, err=1, carry=0.
REQ-046 SHALL cover: rst_n=0 for one cycle with 2 ops in flight -> out_valid=0 next cycle, no stale result emitted, in_ready=1 after release.
